// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with a one-cycle terminal pulse.
// Supports one-shot or auto-reload operation, with pause/resume via stop/start.
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] reload_reg, reload_next, count_next;
  logic             done_next;

  // Priority is load > stop > start > en; stop also blocks a start from IDLE.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    done_next   = 1'b0;
    if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      state_next  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop && (count != '0))
            state_next = RUN;
        end
        RUN: begin
          if (stop) begin
            state_next = PAUSE;
          end else if (en) begin
            if (count == WIDTH'(1)) begin
              done_next = 1'b1;
              if (auto_reload && (reload_reg != '0)) begin
                count_next = reload_reg;
              end else begin
                count_next = '0;
                state_next = IDLE;
              end
            end else if (count != '0) begin
              count_next = count - WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (start && !stop)
            state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      busy       <= (state_next == RUN) || (state_next == PAUSE);
      done       <= done_next;
    end
  end

endmodule
